// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes, functs,
// ALU operation codes, mux select codes and the instruction class decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IXEC   = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd15
  } state_e;

  typedef enum logic [2:0] {CL_MEM, CL_R, CL_I, CL_BR, CL_J, CL_ILL} instr_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  function automatic instr_class_e classify(input logic [5:0] op, input logic [5:0] fn);
    instr_class_e cls;
    cls = CL_ILL;
    case (op)
      OP_LW, OP_SW: cls = CL_MEM;
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: cls = CL_R;
          default: cls = CL_ILL;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI: cls = CL_I;
      OP_BEQ, OP_BNE: cls = CL_BR;
      OP_J: cls = CL_J;
      default: cls = CL_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decode.sv
// Combinational ALU operation and immediate-extension select from state, opcode and funct.
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       imm_zext
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    imm_zext = 1'b0;
    case (state)
      S_BRANCH: alu_ctrl = ALU_SUB;
      S_RXEC: begin
        case (funct)
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      S_IXEC: begin
        case (opcode)
          OP_ANDI:  begin alu_ctrl = ALU_AND; imm_zext = 1'b1; end
          OP_ORI:   begin alu_ctrl = ALU_OR;  imm_zext = 1'b1; end
          OP_SLTI:  alu_ctrl = ALU_SLT;
          OP_SLTIU: alu_ctrl = ALU_SLTU;
          default:  alu_ctrl = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath.
// Define MIPS_CTRL_PERF_EN to add cycle_count/instr_count performance counters.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [3:0] alu_ctrl,
  output logic       illegal,
  output logic [3:0] state
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  state_e     state_q, state_d;
  logic [3:0] alu_ctrl_dec;
  logic       imm_zext_dec;

  mips_alu_decode u_alu_decode (
    .state    (state_q),
    .opcode   (opcode),
    .funct    (funct),
    .alu_ctrl (alu_ctrl_dec),
    .imm_zext (imm_zext_dec)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (classify(opcode, funct))
          CL_MEM:  state_d = S_MEMADR;
          CL_R:    state_d = S_RXEC;
          CL_I:    state_d = S_IXEC;
          CL_BR:   state_d = S_BRANCH;
          CL_J:    state_d = S_JUMP;
          default: state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_RXEC:   state_d = S_RWB;
      S_IXEC:   state_d = S_IWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore strobes per state; BRANCH pc_en follows zero combinationally.
  always_comb begin
    pc_en      = 1'b0;
    pc_src     = PC_SRC_ALU;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_ctrl   = alu_ctrl_dec;
    imm_zext   = imm_zext_dec;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_en     = 1'b1;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_RXEC: alu_src_a = 1'b1;
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_IXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_IWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = PC_SRC_ALUOUT;
        pc_en     = zero ^ (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_src = PC_SRC_JUMP;
        pc_en  = 1'b1;
      end
      S_TRAP: begin
        alu_ctrl = 4'b0000;
        imm_zext = 1'b0;
        illegal  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_en     = 1'b0;
      pc_src    = 2'b00;
      iord      = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_dst   = 1'b0;
      mem_to_reg = 1'b0;
      reg_write = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      alu_ctrl  = 4'b0000;
      imm_zext  = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign state = state_q;

`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else if (state_q != S_TRAP) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (state_d == S_FETCH && state_q != S_FETCH) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_count = cycle_cnt_q;
  assign instr_count = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected control vectors.
module tb_mips_multicycle_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic zero = 1'b0;

  logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic alu_src_a, imm_zext, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_ctrl, state;

  logic n_pc_en, n_iord, n_mem_read, n_mem_write, n_ir_write, n_reg_dst, n_mem_to_reg;
  logic n_reg_write, n_alu_src_a, n_imm_zext, n_illegal;
  logic [1:0] n_pc_src, n_alu_src_b;
  logic [3:0] n_alu_ctrl, n_state;

`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] cycle_count, instr_count, n_cycle_count, n_instr_count;
`endif

  always #5 clock = ~clock;

  mips_multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .state(state)
`ifdef MIPS_CTRL_PERF_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  mips_multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(n_pc_en), .pc_src(n_pc_src), .iord(n_iord), .mem_read(n_mem_read),
    .mem_write(n_mem_write), .ir_write(n_ir_write), .reg_dst(n_reg_dst),
    .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .imm_zext(n_imm_zext), .alu_ctrl(n_alu_ctrl),
    .illegal(n_illegal), .state(n_state)
`ifdef MIPS_CTRL_PERF_EN
    , .cycle_count(n_cycle_count), .instr_count(n_instr_count)
`endif
  );

  logic [31:0] obs;
  assign obs = {9'd0, state, pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, imm_zext, alu_ctrl, illegal};

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] sb[$];
  logic [31:0] sb_nop[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected vector: state, pc_en, pc_src, iord, rd, wr, irw, rdst, m2r, rw, srcA, srcB, zext, alu, ill
  function automatic logic [31:0] mk(input logic [3:0] st, input logic pe, input logic [1:0] ps,
                                     input logic io, input logic mr, input logic mw,
                                     input logic irw, input logic rd, input logic m2r,
                                     input logic rw, input logic sa, input logic [1:0] sbv,
                                     input logic zx, input logic [3:0] alu, input logic ill);
    return {9'd0, st, pe, ps, io, mr, mw, irw, rd, m2r, rw, sa, sbv, zx, alu, ill};
  endfunction

  function automatic logic [31:0] v_fetch();
    return mk(4'd0, 1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 0, 4'b0010, 0);
  endfunction
  function automatic logic [31:0] v_decode();
    return mk(4'd1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 4'b0010, 0);
  endfunction
  function automatic logic [31:0] v_memadr();
    return mk(4'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 4'b0010, 0);
  endfunction

  task automatic drain(input string tag);
    logic [31:0] e;
    while (sb.size() > 0) begin
      #2;
      e = sb.pop_front();
      chk(tag, obs, e);
      chk({tag, "_excl"}, {31'd0, (mem_read & mem_write) | (reg_write & pc_en)}, 32'd0);
      if (sb_nop.size() > 0) chk({tag, "_nop"}, {28'd0, n_state}, sb_nop.pop_front());
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #2;
    chk("rst_out", obs, 32'd0);
    chk("rst_nop", {28'd0, n_state}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // lw: 5 cycles, MDR writeback only in the last one
    opcode = 6'b100011; funct = 6'd0; zero = 1'b0;
    sb.push_back(v_fetch()); sb.push_back(v_decode()); sb.push_back(v_memadr());
    sb.push_back(mk(4'd3, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0010, 0));
    sb.push_back(mk(4'd4, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 4'b0010, 0));
    drain("lw");

    // nor R-type
    opcode = 6'b000000; funct = 6'b100111;
    sb.push_back(v_fetch()); sb.push_back(v_decode());
    sb.push_back(mk(4'd6, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 4'b1100, 0));
    sb.push_back(mk(4'd7, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 4'b0010, 0));
    drain("nor");

    // bne taken/not taken
    opcode = 6'b000101; funct = 6'd0; zero = 1'b1;
    sb.push_back(v_fetch()); sb.push_back(v_decode());
    sb.push_back(mk(4'd10, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 4'b0110, 0));
    drain("bne_z1");
    zero = 1'b0;
    sb.push_back(v_fetch()); sb.push_back(v_decode());
    sb.push_back(mk(4'd10, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 4'b0110, 0));
    drain("bne_z0");

    // beq taken
    opcode = 6'b000100; zero = 1'b1;
    sb.push_back(v_fetch()); sb.push_back(v_decode());
    sb.push_back(mk(4'd10, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 4'b0110, 0));
    drain("beq_z1");
    zero = 1'b0;

    // ori zero-extends, sltiu sign-extends
    opcode = 6'b001101;
    sb.push_back(v_fetch()); sb.push_back(v_decode());
    sb.push_back(mk(4'd8, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 4'b0001, 0));
    sb.push_back(mk(4'd9, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 4'b0010, 0));
    drain("ori");
    opcode = 6'b001011;
    sb.push_back(v_fetch()); sb.push_back(v_decode());
    sb.push_back(mk(4'd8, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 4'b1000, 0));
    sb.push_back(mk(4'd9, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 4'b0010, 0));
    drain("sltiu");

    // j
    opcode = 6'b000010;
    sb.push_back(v_fetch()); sb.push_back(v_decode());
    sb.push_back(mk(4'd11, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0010, 0));
    drain("j");

    // illegal opcode: sticky TRAP; the NOP variant returns to FETCH
    opcode = 6'b111111;
    sb.push_back(v_fetch()); sb.push_back(v_decode());
    for (int i = 0; i < 10; i++)
      sb.push_back(mk(4'd15, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 1));
    sb_nop.push_back(32'd0); sb_nop.push_back(32'd1); sb_nop.push_back(32'd0);
    drain("ill");

    // illegal R-type funct
    do_reset();
    opcode = 6'b000000; funct = 6'b111111;
    sb.push_back(v_fetch()); sb.push_back(v_decode());
    sb.push_back(mk(4'd15, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 1));
    drain("ill_fn");

    // reset during MEMWR abandons the store immediately
    do_reset();
    opcode = 6'b101011; funct = 6'd0;
    sb.push_back(v_fetch()); sb.push_back(v_decode()); sb.push_back(v_memadr());
    drain("sw_pre");
    #2;
    chk("memwr_pre", obs, mk(4'd5, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0010, 0));
    reset = 1'b1;
    #1;
    chk("memwr_rst", obs, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #2;
    chk("after_rst", obs, v_fetch());
    @(negedge clock);

    // sw then j from a clean reset: 7 cycles, 2 instructions
    do_reset();
    opcode = 6'b101011;
    sb.push_back(v_fetch()); sb.push_back(v_decode()); sb.push_back(v_memadr());
    sb.push_back(mk(4'd5, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0010, 0));
    drain("sw");
    opcode = 6'b000010;
    sb.push_back(v_fetch()); sb.push_back(v_decode());
    sb.push_back(mk(4'd11, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0010, 0));
    drain("sw_j");
`ifdef MIPS_CTRL_PERF_EN
    #2;
    chk("cycle_count", cycle_count, 32'd7);
    chk("instr_count", instr_count, 32'd2);
    opcode = 6'b111111;
    repeat (5) @(negedge clock);
    #2;
    chk("trap_cycles", cycle_count, 32'd9);
    chk("trap_instrs", instr_count, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
